// File: rtl/i2c_master_core.sv
// Byte-level I2C bit engine: executes one START/WRITE/READ/STOP command at a time
// and drives open-drain SCL/SDA enables with quarter-period timing.
module i2c_master_core #(
    parameter int unsigned DIV_Q = 250
) (
    input  logic       ACLK,
    input  logic       ARESETN,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] tx_data,
    input  logic       ack_in,
    output logic [7:0] rx_data,
    output logic       ack_out,
    output logic       done,
    output logic       err,
    output logic       busy,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_oe,
    output logic       sda_oe
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(DIV_Q - 1);
    localparam logic [CNT_W-1:0] Q_PRE  = CNT_W'(DIV_Q - 2);

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WRITE,
        S_READ,
        S_STOP,
        S_HOLD
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] q_cnt, q_cnt_n;
    logic [1:0]       qtr, qtr_n;
    logic [3:0]       bit_cnt, bit_n;
    logic [7:0]       tx_sh, tx_n;
    logic [7:0]       rx_sh, rx_sh_n;
    logic             ack_lat, ack_lat_n;
    logic [7:0]       rx_n;
    logic             ack_out_n, done_n, err_n, busy_n, ready_n, scl_n, sda_n;
    logic             enter, last_q;

    // State and registered outputs
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state     <= S_IDLE;
            q_cnt     <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            ack_lat   <= 1'b0;
            rx_data   <= '0;
            ack_out   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            state     <= state_n;
            q_cnt     <= q_cnt_n;
            qtr       <= qtr_n;
            bit_cnt   <= bit_n;
            tx_sh     <= tx_n;
            rx_sh     <= rx_sh_n;
            ack_lat   <= ack_lat_n;
            rx_data   <= rx_n;
            ack_out   <= ack_out_n;
            done      <= done_n;
            err       <= err_n;
            busy      <= busy_n;
            cmd_ready <= ready_n;
            scl_oe    <= scl_n;
            sda_oe    <= sda_n;
        end
    end

    // Next-state, quarter timer and line control
    always_comb begin
        state_n   = state;
        q_cnt_n   = q_cnt;
        qtr_n     = qtr;
        bit_n     = bit_cnt;
        tx_n      = tx_sh;
        rx_sh_n   = rx_sh;
        ack_lat_n = ack_lat;
        rx_n      = rx_data;
        ack_out_n = ack_out;
        done_n    = 1'b0;
        err_n     = 1'b0;
        busy_n    = busy;
        ready_n   = cmd_ready | done;
        scl_n     = scl_oe;
        sda_n     = sda_oe;
        enter     = 1'b0;
        last_q    = (qtr == 2'd3) &&
                    ((state == S_START) || (state == S_STOP) || (bit_cnt == 4'd8));

        case (state)
            S_IDLE, S_HOLD: begin
                if (state == S_HOLD) scl_n = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    ready_n   = 1'b0;
                    tx_n      = tx_data;
                    ack_lat_n = ack_in;
                    q_cnt_n   = '0;
                    qtr_n     = '0;
                    bit_n     = '0;
                    if ((state == S_IDLE) && (cmd != CMD_START)) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else begin
                        enter  = 1'b1;
                        busy_n = 1'b1;
                        case (cmd)
                            CMD_START: state_n = S_START;
                            CMD_WRITE: state_n = S_WRITE;
                            CMD_READ:  state_n = S_READ;
                            CMD_STOP:  state_n = S_STOP;
                            default:   state_n = S_IDLE;
                        endcase
                    end
                end
            end
            default: begin
                // done is registered, so it is raised one cycle ahead of the final edge
                if ((q_cnt == Q_PRE) && last_q) begin
                    done_n = 1'b1;
                    if (state == S_STOP) busy_n = 1'b0;
                    if (state == S_READ) rx_n = rx_sh;
                end
                if (q_cnt != Q_LAST) begin
                    q_cnt_n = q_cnt + CNT_W'(1);
                end else if (!((qtr == 2'd1) && !scl_oe && !scl_i)) begin
                    q_cnt_n = '0;
                    if (qtr == 2'd2) begin
                        if ((state == S_WRITE) && (bit_cnt == 4'd8)) ack_out_n = sda_i;
                        if ((state == S_READ) && (bit_cnt != 4'd8)) rx_sh_n = {rx_sh[6:0], sda_i};
                    end
                    if (qtr == 2'd3) begin
                        qtr_n = '0;
                        if (last_q) begin
                            bit_n   = '0;
                            state_n = (state == S_STOP) ? S_IDLE : S_HOLD;
                        end else begin
                            bit_n = bit_cnt + 4'd1;
                            tx_n  = {tx_sh[6:0], 1'b0};
                            enter = 1'b1;
                        end
                    end else begin
                        qtr_n = qtr + 2'd1;
                        enter = 1'b1;
                    end
                end
            end
        endcase

        // Line levels applied on the first cycle of each quarter
        if (enter) begin
            case (state_n)
                S_START: begin
                    case (qtr_n)
                        2'd0:    sda_n = 1'b0;
                        2'd1:    scl_n = 1'b0;
                        2'd2:    sda_n = 1'b1;
                        default: scl_n = 1'b1;
                    endcase
                end
                S_WRITE, S_READ: begin
                    case (qtr_n)
                        2'd0: begin
                            scl_n = 1'b1;
                            if (state_n == S_WRITE)
                                sda_n = (bit_n == 4'd8) ? 1'b0 : ~tx_n[7];
                            else
                                sda_n = (bit_n == 4'd8) ? ~ack_lat_n : 1'b0;
                        end
                        2'd1:    scl_n = 1'b0;
                        2'd3:    scl_n = 1'b1;
                        default: ;
                    endcase
                end
                S_STOP: begin
                    case (qtr_n)
                        2'd0: begin
                            scl_n = 1'b1;
                            sda_n = 1'b1;
                        end
                        2'd1:    scl_n = 1'b0;
                        2'd3:    sda_n = 1'b0;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core with DIV_Q=4 and a simple open-drain slave model.
module tb_i2c_master_core;

    logic       ACLK;
    logic       ARESETN;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       ack_in;
    logic [7:0] rx_data;
    logic       ack_out;
    logic       done;
    logic       err;
    logic       busy;
    logic       scl_i;
    logic       sda_i;
    logic       scl_oe;
    logic       sda_oe;

    logic slave_low;
    logic stretch;
    int   n_cmp;
    int   n_err;

    assign scl_i = ~(scl_oe | stretch);
    assign sda_i = ~(sda_oe | slave_low);

    i2c_master_core #(.DIV_Q(4)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .tx_data   (tx_data),
        .ack_in    (ack_in),
        .rx_data   (rx_data),
        .ack_out   (ack_out),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one command; returns on the first cycle after the accept edge
    task automatic issue(input logic [1:0] c, input logic [7:0] d, input logic a,
                         output logic ps, output logic pd);
        int w;
        w = 0;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd       = c;
        tx_data   = d;
        ack_in    = a;
        ps        = scl_oe;
        pd        = sda_oe;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Run a command to done while modelling the slave; pat[8-k] = slave pulls SDA in bit k
    task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                          input logic [8:0] pat, input int st_at,
                          output int steps, output logic [8:0] cap, output logic sda_any,
                          output logic start_seen, output logic stop_seen, output int fall3,
                          output logic busy_d, output logic [7:0] rx_prev);
        int   falls;
        logic p_scl, p_sda;
        falls = 0; cap = '0; sda_any = 1'b0; start_seen = 1'b0; stop_seen = 1'b0;
        fall3 = -1; steps = -1; busy_d = 1'b0; rx_prev = rx_data;
        slave_low = pat[8];
        issue(c, d, a, p_scl, p_sda);
        for (int s = 1; s <= 400; s++) begin
            if (st_at > 0 && s == st_at) stretch = 1'b1;
            if (st_at > 0 && s == st_at + 10) stretch = 1'b0;
            if (p_scl && !scl_oe) cap = {cap[7:0], sda_oe};
            if (!p_scl && scl_oe) begin
                falls++;
                if (falls == 3) fall3 = s;
            end
            slave_low = (falls < 9) ? pat[8-falls] : 1'b0;
            if (!p_scl && !scl_oe && !p_sda && sda_oe) start_seen = 1'b1;
            if (!p_scl && !scl_oe && p_sda && !sda_oe) stop_seen = 1'b1;
            sda_any = sda_any | sda_oe;
            if (done) begin
                steps  = s;
                busy_d = busy;
                break;
            end
            rx_prev = rx_data;
            p_scl   = scl_oe;
            p_sda   = sda_oe;
            tick();
        end
        slave_low = 1'b0;
        stretch   = 1'b0;
    endtask

    initial begin
        int         st;
        int         f3;
        logic [8:0] cp;
        logic       sa, ss, sp, bd, ps, pd;
        logic [7:0] rp;

        n_cmp = 0; n_err = 0;
        ARESETN = 1'b0; cmd_valid = 1'b0; cmd = 2'b00; tx_data = 8'h00; ack_in = 1'b0;
        slave_low = 1'b0; stretch = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_ack_out", 32'(ack_out), 32'd0);
        ARESETN = 1'b1;
        tick();

        // Illegal WRITE while idle
        issue(2'b01, 8'h77, 1'b0, ps, pd);
        check("ill_done", 32'(done), 32'd1);
        check("ill_err", 32'(err), 32'd1);
        check("ill_ready_drop", 32'(cmd_ready), 32'd0);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_scl_oe", 32'(scl_oe), 32'd0);
        check("ill_sda_oe", 32'(sda_oe), 32'd0);
        tick();
        check("ill_done_pulse", 32'(done), 32'd0);
        check("ill_ready_back", 32'(cmd_ready), 32'd1);

        // START from idle
        do_cmd(2'b00, 8'h00, 1'b0, 9'h000, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("start_cycles", 32'(st), 32'd16);
        check("start_cond", 32'(ss), 32'd1);
        check("start_busy", 32'(bd), 32'd1);
        check("start_err", 32'(err), 32'd0);
        check("start_scl_oe", 32'(scl_oe), 32'd1);
        check("start_sda_oe", 32'(sda_oe), 32'd1);

        // WRITE 0x3C, no slave ACK
        do_cmd(2'b01, 8'h3C, 1'b0, 9'h000, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("w3c_cycles", 32'(st), 32'd144);
        check("w3c_ack_out", 32'(ack_out), 32'd1);
        check("w3c_err", 32'(err), 32'd0);
        check("w3c_sda_bits", 32'(cp), 32'h186);
        check("w3c_fall3", 32'(f3), 32'd45);
        tick();
        check("w3c_hold_ready", 32'(cmd_ready), 32'd1);
        check("w3c_hold_scl", 32'(scl_oe), 32'd1);
        check("w3c_busy", 32'(busy), 32'd1);

        // WRITE 0xA4, slave ACKs bit 9
        do_cmd(2'b01, 8'hA4, 1'b0, 9'h001, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("wa4_cycles", 32'(st), 32'd144);
        check("wa4_ack_out", 32'(ack_out), 32'd0);
        check("wa4_sda_bits", 32'(cp), 32'h0B6);
        check("wa4_no_start", 32'(ss), 32'd0);
        check("wa4_no_stop", 32'(sp), 32'd0);
        check("wa4_busy", 32'(bd), 32'd1);

        // WRITE 0x55 with the slave stretching SCL for 10 cycles in bit 3
        do_cmd(2'b01, 8'h55, 1'b0, 9'h001, 40, st, cp, sa, ss, sp, f3, bd, rp);
        check("wst_cycles", 32'(st), 32'd154);
        check("wst_fall3", 32'(f3), 32'd55);
        check("wst_sda_bits", 32'(cp), 32'h154);
        check("wst_ack_out", 32'(ack_out), 32'd0);

        // READ 0x5A, master NACKs
        do_cmd(2'b10, 8'h00, 1'b1, 9'h14A, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("rd_cycles", 32'(st), 32'd144);
        check("rd_rx_data", 32'(rx_data), 32'h5A);
        check("rd_rx_before_done", 32'(rp), 32'h00);
        check("rd_sda_released", 32'(sa), 32'd0);
        check("rd_err", 32'(err), 32'd0);

        // STOP
        do_cmd(2'b11, 8'h00, 1'b0, 9'h000, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("stop_cycles", 32'(st), 32'd16);
        check("stop_cond", 32'(sp), 32'd1);
        check("stop_busy", 32'(bd), 32'd0);
        check("stop_scl_oe", 32'(scl_oe), 32'd0);
        check("stop_sda_oe", 32'(sda_oe), 32'd0);
        tick();
        check("stop_ready", 32'(cmd_ready), 32'd1);

        // Reset in the middle of a WRITE
        do_cmd(2'b00, 8'h00, 1'b0, 9'h000, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("start2_cycles", 32'(st), 32'd16);
        issue(2'b01, 8'h00, 1'b0, ps, pd);
        for (int i = 0; i < 66; i++) tick();
        check("mid_scl_oe", 32'(scl_oe), 32'd1);
        check("mid_sda_oe", 32'(sda_oe), 32'd1);
        ARESETN = 1'b0;
        tick();
        ARESETN = 1'b1;
        check("arst_scl_oe", 32'(scl_oe), 32'd0);
        check("arst_sda_oe", 32'(sda_oe), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);
        check("arst_rx_data", 32'(rx_data), 32'd0);

        do_cmd(2'b00, 8'h00, 1'b0, 9'h000, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("start3_cycles", 32'(st), 32'd16);
        check("start3_busy", 32'(bd), 32'd1);
        check("start3_cond", 32'(ss), 32'd1);
        do_cmd(2'b11, 8'h00, 1'b0, 9'h000, 0, st, cp, sa, ss, sp, f3, bd, rp);
        check("stop3_cycles", 32'(st), 32'd16);
        check("stop3_busy", 32'(bd), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
- Byte-level I2C bit engine inside the I2C_Master AXI4-Lite peripheral.
- Sits directly downstream of the AXI4-Lite slave register file: register logic issues one command (START/WRITE/READ/STOP) at a time; this block generates SCL/SDA timing and returns received data and ACK status for software readback.
- Open-drain outputs; the top level builds the IOBUF tristates.

Parameters:
- DIV_Q, 250, ACLK cycles per SCL quarter-period (100 MHz / (4*250) = 100 kHz); legal range 2..65535.

Ports:
- ACLK  in  1  system clock
- ARESETN  in  1  synchronous active-low reset
- cmd_valid  in  1  command request from register file
- cmd_ready  out  1  core can accept a command this cycle
- cmd  in  2  00 START, 01 WRITE, 10 READ, 11 STOP
- tx_data  in  8  byte for WRITE, sampled on accept
- ack_in  in  1  ACK bit to drive after READ (0 = ACK, 1 = NACK), sampled on accept
- rx_data  out  8  last byte received by READ
- ack_out  out  1  ACK sampled on WRITE 9th bit (1 = NACK)
- done  out  1  one-cycle pulse at command completion
- err  out  1  valid with done; 1 = illegal command
- busy  out  1  bus owned (START issued, STOP not finished)
- scl_i  in  1  SCL pad input
- sda_i  in  1  SDA pad input
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release

Behaviour:
- Reset (ARESETN=0 at ACLK edge): state IDLE, scl_oe=0, sda_oe=0, rx_data=0, ack_out=0, done=0, err=0, busy=0, cmd_ready=1, quarter counter=0, bit counter=0. Reset mid-transfer releases both lines on that same edge; no STOP is generated.
- Handshake: command accepted when cmd_valid & cmd_ready. cmd_ready=1 only in IDLE and HOLD. tx_data/ack_in are latched on accept. cmd_ready drops on the cycle after accept.
- Quarter timer: counts DIV_Q cycles per quarter (q0..q3). At the end of q1, if scl_oe=0 and scl_i=0 (clock stretching), the timer holds until scl_i=1. q2 then starts a full DIV_Q count.
- States: IDLE, START, WRITE, READ, STOP, HOLD.
- IDLE:
  - START -> START, busy=1.
  - WRITE/READ/STOP -> no bus activity; done=1 and err=1 on the cycle after accept; stays IDLE.
- START, 4 quarters, also used as repeated START from HOLD:
  - q0: sda_oe=0, scl_oe unchanged.
  - q1: scl_oe=0.
  - q2: sda_oe=1.
  - q3: scl_oe=1.
  - -> HOLD.
- WRITE, 9 bits x 4 quarters, MSB first:
  - Per bit: q0 scl_oe=1 and SDA set (sda_oe = ~bit; released for the 9th bit); q1 scl_oe=0; q2 SCL high, sda_i sampled on the last cycle of q2; q3 scl_oe=1.
  - The 9th-bit sample goes to ack_out.
  - -> HOLD.
- READ, 9 bits:
  - Bits 1-8: sda_oe=0; sampled bits shift into rx_data MSB first. rx_data updates only at the end of the byte (the shift register is internal).
  - Bit 9: sda_oe = ~ack_in.
  - -> HOLD.
- STOP, 4 quarters:
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0.
  - q2: hold.
  - q3: sda_oe=0.
  - -> IDLE, busy=0 on the same cycle done pulses.
- HOLD: SCL held low (scl_oe=1), SDA unchanged. Accepts any command; START is a repeated start.
- Completion: done pulses on the last cycle of the final quarter, err=0 (the illegal-command case is the only err=1 source). The next command can be accepted one cycle after done.
- Bit timing, no stretching: START/STOP = 4*DIV_Q cycles; WRITE/READ = 36*DIV_Q cycles from accept+1 to done.
- No arbitration-loss detection. Bit 9 of READ is not sampled.

Test Plan:
- DIV_Q=4, START then WRITE 0xA4, slave pulls SDA low in bit 9 -> SDA at SCL rising edges = 1,0,1,0,0,1,0,0, released on bit 9; ack_out=0; WRITE done exactly 144 cycles after accept+1; busy=1.
- WRITE 0x3C with no slave ACK (SDA floats high) -> ack_out=1, err=0, state HOLD, scl_oe=1.
- READ with ack_in=1, slave drives 0x5A -> rx_data=0x5A at done; sda_oe=0 for all 9 bits; then STOP -> SDA rises while SCL high, busy=0 with done, both oe=0.
- Slave holds scl_i low 10 extra cycles after q1 of bit 3 of a WRITE -> total WRITE duration 154 cycles; q2 still 4 cycles long.
- WRITE issued in IDLE -> done=1, err=1 one cycle after accept; scl_oe/sda_oe stay 0; busy stays 0.
- ARESETN=0 during bit 5 of a WRITE -> next edge scl_oe=0, sda_oe=0, busy=0, cmd_ready=1, rx_data=0; a following START completes normally.
